// File: rtl/unified_mem_arbiter.sv
// Purpose: shares one single-ported memory between IF (read-only) and D (load/store).
// Latency: req sampled in IDLE -> mem_req next cycle -> done one cycle after mem_ready (min 3 cycles).
// Backpressure: mem_req is held until mem_ready or timeout; requests are sampled only in IDLE.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   if_req/if_addr               IF read request and byte address
//   if_done/if_err/if_rdata      IF completion pulse, error flag, read data (held)
//   d_req/d_we/d_addr/d_wdata    D load/store request
//   d_done/d_err/d_rdata         D completion pulse, error flag, load data (held)
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, stable until mem_ready or abort
//   mem_rdata/mem_ready          memory read data and completion
module unified_mem_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic              if_err,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state;
    logic            owner_d;    // 1 = D owns the current transaction, 0 = IF
    logic [SW-1:0]   streak;     // consecutive D grants taken while IF was waiting
    logic [TW-1:0]   tcnt;       // cycles spent in BUSY without mem_ready

    logic            grant_d;
    logic            misal;
    logic [ADDR_W-1:0] sel_addr;

    // D wins unless IF is waiting and D has already used up its streak.
    always_comb begin
        grant_d  = d_req && (!if_req || (streak < STREAK_MAX));
        sel_addr = grant_d ? d_addr : if_addr;
        misal    = grant_d ? (d_addr[2:0] != 3'b000) : (if_addr[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            streak    <= '0;
            tcnt      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            d_done    <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        owner_d <= grant_d;
                        if (grant_d && if_req) begin
                            if (streak != STREAK_MAX)
                                streak <= streak + SW'(1);
                        end else begin
                            streak <= '0;
                        end
                        if (misal) begin
                            // Misaligned: answer with an error, memory is never touched.
                            state <= RESP;
                            if (grant_d) begin
                                d_done <= 1'b1;
                                d_err  <= 1'b1;
                            end else begin
                                if_done <= 1'b1;
                                if_err  <= 1'b1;
                            end
                        end else begin
                            // The memory-side registers double as the request latch.
                            state     <= BUSY;
                            tcnt      <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= grant_d && d_we;
                            mem_addr  <= sel_addr;
                            mem_wdata <= grant_d ? d_wdata : '0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (owner_d) begin
                            d_rdata <= mem_rdata;
                            d_done  <= 1'b1;
                            d_err   <= 1'b0;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_done  <= 1'b1;
                            if_err   <= 1'b0;
                        end
                    end else if (tcnt == TCNT_LAST) begin
                        // Abort: read data registers keep their previous contents.
                        state   <= RESP;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (owner_d) begin
                            d_done <= 1'b1;
                            d_err  <= 1'b1;
                        end else begin
                            if_done <= 1'b1;
                            if_err  <= 1'b1;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    if_done <= 1'b0;
                    if_err  <= 1'b0;
                    d_done  <= 1'b0;
                    d_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
